// File: rtl/game_timer_pkg.sv
// ---------------------------------------------------------------------------
// game_timer_pkg
// Shared game definitions used by the countdown timer and game setup logic.
//   timer_state_t      : timer FSM state encoding
//   MAX_TIMER_SECONDS  : largest value the timer will load (3 BCD digits)
//   WARN_SECONDS       : low-time warning threshold (GAME_TIMER_WARN_EN)
//   E/M/H_TIMER_SECONDS: per-difficulty start values fed to timer_seconds
//   bin_to_bcd()       : shift-and-add-3 conversion of a 10-bit value, used
//                        only when loading the timer (no divider involved)
// ---------------------------------------------------------------------------
package game_timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSED  = 3'd2,
    EXPIRED = 3'd3,
    HALTED  = 3'd4
  } timer_state_t;

  localparam int MAX_TIMER_SECONDS = 999;
  localparam int WARN_SECONDS      = 10;

  localparam int E_TIMER_SECONDS = 300;
  localparam int M_TIMER_SECONDS = 200;
  localparam int H_TIMER_SECONDS = 120;

  // Double-dabble: before every shift, any BCD column >= 5 gets +3 so the
  // shift carries correctly into the next decimal digit.
  function automatic logic [11:0] bin_to_bcd(input logic [9:0] bin);
    logic [21:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
      if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
      if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
      sh = sh << 1;
    end
    return sh[21:10];
  endfunction

endpackage

// File: rtl/game_timer_bcd_down_counter.sv
// ---------------------------------------------------------------------------
// bcd_down_counter
// Three-digit BCD down-counter running in parallel with the binary seconds
// counter so the display never needs a binary-to-BCD divider.
//   clk, rst     : clock, asynchronous active-high reset
//   load         : load load_digits (takes priority over dec)
//   load_digits  : {hundreds, tens, ones} to load
//   dec          : decrement by one with borrow; holds at 000
//   hundreds/tens/ones : current digits
// ---------------------------------------------------------------------------
module bcd_down_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] load_digits,
  input  logic        dec,
  output logic [3:0]  hundreds,
  output logic [3:0]  tens,
  output logic [3:0]  ones
);

  logic is_zero;
  assign is_zero = (hundreds == 4'd0) && (tens == 4'd0) && (ones == 4'd0);

  // Borrow chain: a zero digit wraps to 9 and borrows from the next digit up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hundreds <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
    end else if (load) begin
      hundreds <= load_digits[11:8];
      tens     <= load_digits[7:4];
      ones     <= load_digits[3:0];
    end else if (dec && !is_zero) begin
      if (ones != 4'd0) begin
        ones <= ones - 4'd1;
      end else begin
        ones <= 4'd9;
        if (tens != 4'd0) begin
          tens <= tens - 4'd1;
        end else begin
          tens     <= 4'd9;
          hundreds <= hundreds - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/game_timer.sv
// ---------------------------------------------------------------------------
// game_timer
// Countdown game timer. Loads timer_seconds (saturated to 999) on start and
// counts down once per second until zero, a halt, or a new start.
// Parameters: CLK_FREQ_HZ (prescaler terminal count CLK_FREQ_HZ-1),
//             SEC_W (seconds width).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start          : pulse, load timer_seconds and run
//   timer_seconds  : initial seconds, sampled on start
//   pause          : level, hold count (prescaler retained)
//   halt           : pulse, freeze until next start
//   seconds_left   : remaining seconds (binary)
//   bcd_hundreds/bcd_tens/bcd_ones : remaining seconds in BCD
//   running        : high in RUN
//   sec_tick       : pulse on each decrement
//   time_out       : pulse when the count reaches 0
//   warn           : only with GAME_TIMER_WARN_EN defined; blinking
//                    low-time indicator in RUN, steady in PAUSED
// All outputs are registered.
// ---------------------------------------------------------------------------
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 65_000_000,
  parameter int SEC_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEC_W-1:0] timer_seconds,
  input  logic             pause,
  input  logic             halt,
  output logic [SEC_W-1:0] seconds_left,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             running,
  output logic             sec_tick,
`ifdef GAME_TIMER_WARN_EN
  output logic             warn,
`endif
  output logic             time_out
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_RUN     = RUN;
  localparam logic [2:0] S_PAUSED  = PAUSED;
  localparam logic [2:0] S_EXPIRED = EXPIRED;
  localparam logic [2:0] S_HALTED  = HALTED;

  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0]    PRE_TC  = PW'(CLK_FREQ_HZ - 1);
  localparam logic [SEC_W-1:0] MAX_SEC = SEC_W'(MAX_TIMER_SECONDS);
  localparam logic [SEC_W-1:0] ONE_SEC = SEC_W'(1);

  logic [2:0]       state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [SEC_W-1:0] sec_n;
  logic [SEC_W-1:0] load_sec;
  logic [11:0]      load_digits;
  logic             tick_n, timeout_n, dec, run_step;

  assign load_sec    = (timer_seconds > MAX_SEC) ? MAX_SEC : timer_seconds;
  assign load_digits = bin_to_bcd(10'(load_sec));

  // Next-state logic. start overrides everything; in RUN, halt beats pause
  // beats the tick. Releasing pause counts as a normal RUN cycle so the
  // retained prescaler loses no time.
  always_comb begin
    state_n   = state;
    presc_n   = presc;
    sec_n     = seconds_left;
    tick_n    = 1'b0;
    timeout_n = 1'b0;
    dec       = 1'b0;
    run_step  = 1'b0;
    if (start) begin
      sec_n   = load_sec;
      presc_n = '0;
      state_n = (load_sec == '0) ? S_EXPIRED : S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (halt)       state_n = S_HALTED;
          else if (pause) state_n = S_PAUSED;
          else            run_step = 1'b1;
        end
        S_PAUSED: begin
          if (halt)        state_n = S_HALTED;
          else if (!pause) run_step = 1'b1;
        end
        default: ;
      endcase
    end
    if (run_step) begin
      state_n = S_RUN;
      if (presc == PRE_TC) begin
        presc_n = '0;
        if (seconds_left != '0) begin
          dec    = 1'b1;
          tick_n = 1'b1;
          sec_n  = seconds_left - ONE_SEC;
          if (seconds_left == ONE_SEC) begin
            timeout_n = 1'b1;
            state_n   = S_EXPIRED;
          end
        end
      end else begin
        presc_n = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      presc        <= '0;
      seconds_left <= '0;
      sec_tick     <= 1'b0;
      time_out     <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_n;
      presc        <= presc_n;
      seconds_left <= sec_n;
      sec_tick     <= tick_n;
      time_out     <= timeout_n;
      running      <= (state_n == S_RUN);
    end
  end

  bcd_down_counter u_bcd (
    .clk         (clk),
    .rst         (rst),
    .load        (start),
    .load_digits (load_digits),
    .dec         (dec),
    .hundreds    (bcd_hundreds),
    .tens        (bcd_tens),
    .ones        (bcd_ones)
  );

`ifdef GAME_TIMER_WARN_EN
  localparam logic [PW-1:0]    PRE_HALF = PW'(CLK_FREQ_HZ / 2 - 1);
  localparam logic [SEC_W-1:0] WARN_SEC = SEC_W'(WARN_SECONDS);

  logic warn_n, toggle_pt;

  assign toggle_pt = run_step && ((presc == PRE_HALF) || (presc == PRE_TC));

  // warn turns on when the count first drops into the warning band (or is
  // loaded inside it), then blinks at each half-second point while running.
  always_comb begin
    warn_n = 1'b0;
    if (state_n == S_PAUSED) begin
      warn_n = warn;
    end else if (state_n == S_RUN && sec_n <= WARN_SEC) begin
      if (start || seconds_left > WARN_SEC) warn_n = 1'b1;
      else if (toggle_pt)                    warn_n = ~warn;
      else                                   warn_n = warn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) warn <= 1'b0;
    else     warn <= warn_n;
  end
`endif

endmodule

// File: tb/tb_game_timer.sv
// ---------------------------------------------------------------------------
// tb_game_timer
// Directed self-checking bench for game_timer with CLK_FREQ_HZ=10, so one
// second is ten clocks. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point. With GAME_TIMER_WARN_EN defined the
// warn output is exercised as well.
// ---------------------------------------------------------------------------
module tb_game_timer;
  import game_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] timer_seconds;
  logic       pause;
  logic       halt;
  logic [9:0] seconds_left;
  logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
  logic       running, sec_tick, time_out;
`ifdef GAME_TIMER_WARN_EN
  logic       warn;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int count;

  game_timer #(.CLK_FREQ_HZ(10), .SEC_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .timer_seconds (timer_seconds),
    .pause         (pause),
    .halt          (halt),
    .seconds_left  (seconds_left),
    .bcd_hundreds  (bcd_hundreds),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones),
    .running       (running),
    .sec_tick      (sec_tick),
`ifdef GAME_TIMER_WARN_EN
    .warn          (warn),
`endif
    .time_out      (time_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance n cycles and count sec_tick pulses seen.
  task automatic count_ticks(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sec_tick) ticks++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] secs);
    start         = 1'b1;
    timer_seconds = secs;
    step();
    start         = 1'b0;
  endtask

  task automatic check_bcd(input string tag, input int h, input int t, input int o);
    checkOutput({tag, "_h"}, 32'(bcd_hundreds), 32'(h));
    checkOutput({tag, "_t"}, 32'(bcd_tens), 32'(t));
    checkOutput({tag, "_o"}, 32'(bcd_ones), 32'(o));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; timer_seconds = '0; pause = 1'b0; halt = 1'b0;
    step_n(2);
    checkOutput("rst_sec", 32'(seconds_left), 0);
    check_bcd("rst_bcd", 0, 0, 0);
    checkOutput("rst_running", 32'(running), 0);
    checkOutput("rst_tick", 32'(sec_tick), 0);
    checkOutput("rst_timeout", 32'(time_out), 0);
    checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
`ifdef GAME_TIMER_WARN_EN
    checkOutput("rst_warn", 32'(warn), 0);
`endif
    rst = 1'b0;
    step();

    // Basic load and countdown from 3
    $display("[TB] load/count");
    applyStimulus(10'd3);
    checkOutput("ld3_running", 32'(running), 1);
    checkOutput("ld3_sec", 32'(seconds_left), 3);
    check_bcd("ld3_bcd", 0, 0, 3);
    count_ticks(9, count);
    checkOutput("ld3_noearly", 32'(count), 0);
    step();
    checkOutput("t1_tick", 32'(sec_tick), 1);
    checkOutput("t1_sec", 32'(seconds_left), 2);
    step_n(10);
    checkOutput("t2_sec", 32'(seconds_left), 1);
    checkOutput("t2_timeout", 32'(time_out), 0);
    step_n(10);
    checkOutput("t3_sec", 32'(seconds_left), 0);
    checkOutput("t3_timeout", 32'(time_out), 1);
    checkOutput("t3_tick", 32'(sec_tick), 1);
    check_bcd("t3_bcd", 0, 0, 0);
    step();
    checkOutput("exp_timeout_once", 32'(time_out), 0);
    checkOutput("exp_running", 32'(running), 0);
    checkOutput("exp_state", 32'(dut.state), 32'(EXPIRED));
    count_ticks(30, count);
    checkOutput("exp_noticks", 32'(count), 0);
    checkOutput("exp_hold", 32'(seconds_left), 0);

    // Borrow chain and saturation
    $display("[TB] borrow/saturate");
    applyStimulus(10'd100);
    check_bcd("ld100_bcd", 1, 0, 0);
    step_n(10);
    checkOutput("b99_sec", 32'(seconds_left), 99);
    check_bcd("b99_bcd", 0, 9, 9);
    applyStimulus(10'd1023);
    checkOutput("sat_sec", 32'(seconds_left), 999);
    check_bcd("sat_bcd", 9, 9, 9);
    step_n(10);
    checkOutput("sat_dec_sec", 32'(seconds_left), 998);
    check_bcd("sat_dec_bcd", 9, 9, 8);
    applyStimulus(10'd1000);
    checkOutput("sat1000_sec", 32'(seconds_left), 999);
    applyStimulus(10'd0);
    checkOutput("zero_sec", 32'(seconds_left), 0);
    checkOutput("zero_running", 32'(running), 0);
    checkOutput("zero_timeout", 32'(time_out), 0);
    checkOutput("zero_state", 32'(dut.state), 32'(EXPIRED));
    count_ticks(15, count);
    checkOutput("zero_noticks", 32'(count), 0);

    // Pause at prescaler 6 for 50 cycles
    $display("[TB] pause");
    applyStimulus(10'd5);
    step_n(6);
    pause = 1'b1;
    step();
    checkOutput("pause_state", 32'(dut.state), 32'(PAUSED));
    checkOutput("pause_running", 32'(running), 0);
    count_ticks(49, count);
    checkOutput("pause_noticks", 32'(count), 0);
    checkOutput("pause_sec", 32'(seconds_left), 5);
    pause = 1'b0;
    count_ticks(3, count);
    checkOutput("resume_noearly", 32'(count), 0);
    checkOutput("resume_running", 32'(running), 1);
    step();
    checkOutput("resume_tick", 32'(sec_tick), 1);
    checkOutput("resume_sec", 32'(seconds_left), 4);

    // Halt coinciding with a tick at 2 seconds
    $display("[TB] halt");
    applyStimulus(10'd3);
    step_n(10);
    checkOutput("h_pre_sec", 32'(seconds_left), 2);
    step_n(9);
    halt = 1'b1;
    step();
    halt = 1'b0;
    checkOutput("h_sec", 32'(seconds_left), 2);
    checkOutput("h_tick", 32'(sec_tick), 0);
    checkOutput("h_timeout", 32'(time_out), 0);
    checkOutput("h_state", 32'(dut.state), 32'(HALTED));
    count_ticks(20, count);
    checkOutput("h_noticks", 32'(count), 0);
    checkOutput("h_hold", 32'(seconds_left), 2);
    applyStimulus(10'd7);
    checkOutput("h_restart_running", 32'(running), 1);
    checkOutput("h_restart_sec", 32'(seconds_left), 7);
    checkOutput("h_restart_state", 32'(dut.state), 32'(RUN));

    // Asynchronous reset between edges
    $display("[TB] async reset");
    applyStimulus(10'd5);
    step_n(10);
    checkOutput("ar_pre_sec", 32'(seconds_left), 4);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_sec", 32'(seconds_left), 0);
    check_bcd("ar_bcd", 0, 0, 0);
    checkOutput("ar_running", 32'(running), 0);
    checkOutput("ar_state", 32'(dut.state), 32'(IDLE));
    step_n(2);
    #2 rst = 1'b0;
    count_ticks(20, count);
    checkOutput("ar_idle_noticks", 32'(count), 0);
    checkOutput("ar_idle_running", 32'(running), 0);
    checkOutput("ar_idle_state", 32'(dut.state), 32'(IDLE));

`ifdef GAME_TIMER_WARN_EN
    // Warning blink from 12 seconds
    $display("[TB] warn");
    applyStimulus(10'd12);
    checkOutput("w_ld", 32'(warn), 0);
    step_n(10);
    checkOutput("w11", 32'(warn), 0);
    step_n(10);
    checkOutput("w10_sec", 32'(seconds_left), 10);
    checkOutput("w10_on", 32'(warn), 1);
    step_n(4);
    checkOutput("w10_hold", 32'(warn), 1);
    step();
    checkOutput("w10_toggle", 32'(warn), 0);
    step_n(5);
    checkOutput("w9_sec", 32'(seconds_left), 9);
    checkOutput("w9_toggle", 32'(warn), 1);
    pause = 1'b1;
    count = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!warn) count++;
    end
    checkOutput("w_pause_steady", 32'(count), 0);
    pause = 1'b0;
    count = 0;
    for (int i = 0; i < 200 && !time_out; i++) step();
    checkOutput("w_timeout_seen", 32'(time_out), 1);
    checkOutput("w_timeout_off", 32'(warn), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
